sdram_rd_arbiter: RTL and testbench



---
 rtl/sdram_rd_arbiter.sv | 122 ++++++++++++
 tb/tb_sdram_rd_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_arbiter.sv
// Two-requester burst arbiter in front of the SDRAM controller read port.
// Round-robin by default; define SDRAM_RD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 first).
module sdram_rd_arbiter #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8
) (
    input  logic              sdram_clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_avalid,
    output logic              m0_aready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m0_valid,
    input  logic              m0_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_avalid,
    output logic              m1_aready,
    output logic [DATA_W-1:0] m1_data,
    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_avalid,
    input  logic              rd_aready,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic              busy
);

    localparam int                CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]       state;
    logic             grant;
    logic [CNT_W-1:0] beat_cnt;
    logic             winner;
    logic             in_addr;
    logic             in_data;
    logic             addr_fire;
    logic             beat_fire;

`ifdef SDRAM_RD_ARB_FIXED_PRIO_EN
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    always_comb begin
        winner = 1'b0;
        if (!m0_avalid) winner = 1'b1;
    end
`else
    logic last;

    always_comb begin
        winner = 1'b0;
        if (m0_avalid && m1_avalid) winner = ~last;
        else if (m1_avalid)         winner = 1'b1;
    end
`endif

    assign in_addr   = (state == ST_ADDR);
    assign in_data   = (state == ST_DATA);
    assign addr_fire = rd_avalid & rd_aready;
    assign beat_fire = rd_valid & rd_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= 1'b0;
            beat_cnt <= '0;
`ifndef SDRAM_RD_ARB_FIXED_PRIO_EN
            last     <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_avalid || m1_avalid) begin
                        grant <= winner;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (addr_fire) begin
                        beat_cnt <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state <= ST_IDLE;
`ifndef SDRAM_RD_ARB_FIXED_PRIO_EN
                            last  <= grant;
`endif
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshakes are gated by state so a reset drops them immediately.
    assign rd_avalid = in_addr;
    assign rd_addr   = in_addr ? (grant ? m1_addr : m0_addr) : '0;
    assign m0_aready = in_addr & ~grant & rd_aready;
    assign m1_aready = in_addr &  grant & rd_aready;

    assign rd_ready  = in_data & (grant ? m1_ready : m0_ready);
    assign m0_valid  = in_data & ~grant & rd_valid;
    assign m1_valid  = in_data &  grant & rd_valid;
    assign m0_data   = rd_data;
    assign m1_data   = rd_data;

    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed bench for sdram_rd_arbiter; plays both requesters and the SDRAM controller read port.
module tb_sdram_rd_arbiter;

    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 8;

    logic              sdram_clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] m0_addr, m1_addr, rd_addr;
    logic              m0_avalid, m0_aready, m0_valid, m0_ready;
    logic              m1_avalid, m1_aready, m1_valid, m1_ready;
    logic [DATA_W-1:0] m0_data, m1_data, rd_data;
    logic              rd_avalid, rd_aready, rd_valid, rd_ready, busy;

    int checks = 0;
    int errors = 0;

    always #5 sdram_clk = ~sdram_clk;

    sdram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .sdram_clk (sdram_clk), .rst_n     (rst_n),
        .m0_addr   (m0_addr),   .m0_avalid (m0_avalid), .m0_aready (m0_aready),
        .m0_data   (m0_data),   .m0_valid  (m0_valid),  .m0_ready  (m0_ready),
        .m1_addr   (m1_addr),   .m1_avalid (m1_avalid), .m1_aready (m1_aready),
        .m1_data   (m1_data),   .m1_valid  (m1_valid),  .m1_ready  (m1_ready),
        .rd_addr   (rd_addr),   .rd_avalid (rd_avalid), .rd_aready (rd_aready),
        .rd_data   (rd_data),   .rd_valid  (rd_valid),  .rd_ready  (rd_ready),
        .busy      (busy)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick;
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_addr = '0; m0_avalid = 1'b0; m0_ready = 1'b0;
        m1_addr = '0; m1_avalid = 1'b0; m1_ready = 1'b0;
        rd_aready = 1'b0; rd_data = '0; rd_valid = 1'b0;
    endtask

    // Runs one granted burst from IDLE: stall cycles on rd_aready, acceptance, then BURST_LEN beats.
    task automatic do_burst(input int w, input logic [ADDR_W-1:0] exp_addr,
                            input logic [DATA_W-1:0] base, input bit toggle,
                            input bit drop_req, input int stall, input string name);
        int n;
        int cyc;
        logic rdy, got_v, oth_v, got_ar, oth_ar;
        logic [DATA_W-1:0] got_d;
        logic [DATA_W-1:0] exp_d;
        tick;
        rd_aready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            #1;
            checks++;
            if (rd_avalid !== 1'b1 || rd_addr !== exp_addr || m0_aready !== 1'b0 || m1_aready !== 1'b0) begin
                errors++;
                $display("FAIL %s addr_stall[%0d]: rd_avalid=%b rd_addr=%h m0_aready=%b m1_aready=%b, want 1 %h 0 0",
                         name, s, rd_avalid, rd_addr, m0_aready, m1_aready, exp_addr);
            end
            tick;
        end
        rd_aready = 1'b1;
        #1;
        got_ar = (w == 1) ? m1_aready : m0_aready;
        oth_ar = (w == 1) ? m0_aready : m1_aready;
        checks++;
        if (rd_avalid !== 1'b1 || rd_addr !== exp_addr || got_ar !== 1'b1 || oth_ar !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s addr_grant(m%0d): rd_avalid=%b rd_addr=%h aready=%b other_aready=%b busy=%b, want 1 %h 1 0 1",
                     name, w, rd_avalid, rd_addr, got_ar, oth_ar, busy, exp_addr);
        end
        tick;
        rd_aready = 1'b0;
        if (drop_req) begin
            if (w == 1) m1_avalid = 1'b0; else m0_avalid = 1'b0;
        end
        n   = 0;
        cyc = 0;
        while (n < BURST_LEN && cyc < 64) begin
            rdy      = toggle ? ((cyc % 2) == 0) : 1'b1;
            exp_d    = base + DATA_W'(n);
            rd_valid = 1'b1;
            rd_data  = exp_d;
            if (w == 1) m1_ready = rdy; else m0_ready = rdy;
            #1;
            got_v = (w == 1) ? m1_valid : m0_valid;
            oth_v = (w == 1) ? m0_valid : m1_valid;
            got_d = (w == 1) ? m1_data  : m0_data;
            checks++;
            if (got_v !== 1'b1 || oth_v !== 1'b0 || got_d !== exp_d || rd_ready !== rdy ||
                rd_avalid !== 1'b0 || m0_aready !== 1'b0 || m1_aready !== 1'b0) begin
                errors++;
                $display("FAIL %s beat[%0d] cyc %0d: valid=%b other_valid=%b data=%h rd_ready=%b rd_avalid=%b areadys=%b%b, want 1 0 %h %b 0 00",
                         name, n, cyc, got_v, oth_v, got_d, rd_ready, rd_avalid, m0_aready, m1_aready, exp_d, rdy);
            end
            tick;
            if (rdy) n++;
            cyc++;
        end
        rd_valid = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        checks++;
        if (n != BURST_LEN) begin
            errors++;
            $display("FAIL %s beat_budget: delivered %0d beats, want %0d", name, n, BURST_LEN);
        end
        #1;
        checks++;
        if (busy !== 1'b0 || rd_avalid !== 1'b0 || rd_ready !== 1'b0 || m0_valid !== 1'b0 || m1_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s burst_end: busy=%b rd_avalid=%b rd_ready=%b m0_valid=%b m1_valid=%b, want all 0",
                     name, busy, rd_avalid, rd_ready, m0_valid, m1_valid);
        end
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || rd_avalid !== 1'b0 || rd_ready !== 1'b0 || m0_aready !== 1'b0 ||
            m1_aready !== 1'b0 || m0_valid !== 1'b0 || m1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rd_avalid=%b rd_ready=%b aready=%b%b valid=%b%b, want all 0",
                     busy, rd_avalid, rd_ready, m0_aready, m1_aready, m0_valid, m1_valid);
        end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        m0_addr   = 22'h000100;
        m0_avalid = 1'b1;
        #1;
        checks++;
        if (rd_avalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: rd_avalid=%b busy=%b in request cycle, want 0 0", rd_avalid, busy);
        end
        do_burst(0, 22'h000100, 16'hA000, 1'b0, 1'b1, 0, "single");
    endtask

    task automatic test_round_robin;
        int w;
        int exp_last;
        apply_reset();
        exp_last  = 1;
        m0_addr   = 22'h001234;
        m1_addr   = 22'h002345;
        m0_avalid = 1'b1;
        m1_avalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_RD_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (exp_last == 1) ? 0 : 1;
`endif
            do_burst(w, (w == 1) ? 22'h002345 : 22'h001234, 16'h1000 + 16'(k * 16'h0100),
                     1'b0, 1'b0, 0, "round_robin");
            exp_last = w;
        end
        m0_avalid = 1'b0;
        m1_avalid = 1'b0;
        tick;
    endtask

    task automatic test_backpressure;
        m1_addr   = 22'h0ABCDE;
        m1_avalid = 1'b1;
        do_burst(1, 22'h0ABCDE, 16'hB000, 1'b1, 1'b1, 0, "backpressure");
    endtask

    task automatic test_addr_stall;
        m0_addr   = 22'h3F0F0F;
        m0_avalid = 1'b1;
        do_burst(0, 22'h3F0F0F, 16'h5A50, 1'b0, 1'b1, 5, "addr_stall");
    endtask

    task automatic test_stray_data;
        rd_valid = 1'b1;
        rd_data  = 16'hDEAD;
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rd_ready !== 1'b0 || m0_valid !== 1'b0 || m1_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stray_data[%0d]: rd_ready=%b m0_valid=%b m1_valid=%b busy=%b, want 0 0 0 0",
                         i, rd_ready, m0_valid, m1_valid, busy);
            end
            tick;
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst;
        m0_addr   = 22'h003333;
        m0_avalid = 1'b1;
        tick;
        rd_aready = 1'b1;
        tick;
        m0_avalid = 1'b0;
        rd_aready = 1'b0;
        m0_ready  = 1'b1;
        rd_valid  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            rd_data = 16'hC000 + 16'(b);
            tick;
        end
        rd_data = 16'hC003;
        #1;
        checks++;
        if (m0_valid !== 1'b1 || m0_data !== 16'hC003 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_beat3: m0_valid=%b m0_data=%h busy=%b, want 1 c003 1", m0_valid, m0_data, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rd_avalid !== 1'b0 || rd_ready !== 1'b0 || m0_aready !== 1'b0 ||
            m1_aready !== 1'b0 || m0_valid !== 1'b0 || m1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst: busy=%b rd_avalid=%b rd_ready=%b aready=%b%b valid=%b%b, want all 0",
                     busy, rd_avalid, rd_ready, m0_aready, m1_aready, m0_valid, m1_valid);
        end
        clear_inputs();
        tick;
        rst_n = 1'b1;
        tick;
        m1_addr   = 22'h044444;
        m1_avalid = 1'b1;
        do_burst(1, 22'h044444, 16'hE000, 1'b0, 1'b1, 0, "after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_addr_stall();
        test_stray_data();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
